// File: rtl/alu_frame_tx.sv
// ============================================================================
// Module   : alu_frame_tx
// Brief    : Buffers 2..MAX_OPS operands and serialises them MSB-first as
//            odd-parity data frames followed by one command frame.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_frame_tx #(
    parameter int DATA_W  = 8,
    parameter int CMD_W   = 8,
    parameter int MAX_OPS = 9,
    parameter int MIN_OPS = 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         op_valid,
    output logic                         op_ready,
    input  logic [DATA_W-1:0]            op_data,
    input  logic                         cmd_valid,
    output logic                         cmd_ready,
    input  logic [CMD_W-1:0]             cmd_code,
    output logic                         sout,
    output logic                         sout_en,
    output logic                         busy,
    output logic                         done,
    output logic                         err,
    output logic [$clog2(MAX_OPS+1)-1:0] count
);

    localparam int F     = DATA_W + 2;
    localparam int CNT_W = $clog2(MAX_OPS + 1);
    localparam int PTR_W = (MAX_OPS > 1) ? $clog2(MAX_OPS) : 1;
    localparam int BIT_W = $clog2(F);

    typedef enum logic [1:0] {
        S_IDLE       = 2'd0,
        S_SHIFT_DATA = 2'd1,
        S_SHIFT_CMD  = 2'd2,
        S_DONE       = 2'd3
    } state_t;

    state_t              state_q;
    logic [DATA_W-1:0]   fifo_q [MAX_OPS];
    logic [PTR_W-1:0]    wr_ptr_q;
    logic [PTR_W-1:0]    rd_ptr_q;
    logic [CNT_W-1:0]    count_q;
    logic [CMD_W-1:0]    cmd_q;
    logic [F-1:0]        shift_q;
    logic [BIT_W-1:0]    bits_left_q;
    logic                sout_q;
    logic                sout_en_q;
    logic                busy_q;
    logic                done_q;
    logic                err_q;

    logic                w_idle;
    logic                w_push;
    logic                w_cmd;
    logic [CNT_W-1:0]    w_eff_count;
    logic [DATA_W-1:0]   w_head;
    logic [F-1:0]        w_frame;

    function automatic logic [F-1:0] make_frame(input logic is_cmd,
                                                input logic [DATA_W-1:0] payload);
        return {is_cmd, payload, ~^{is_cmd, payload}};
    endfunction

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(MAX_OPS - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign w_idle      = (state_q == S_IDLE);
    assign w_push      = op_valid && op_ready;
    assign w_cmd       = cmd_valid && cmd_ready;
    assign w_eff_count = count_q + CNT_W'(w_push);
    // An empty FIFO with a same-cycle push makes the incoming word the head.
    assign w_head      = (count_q == '0) ? op_data : fifo_q[rd_ptr_q];
    assign w_frame     = (state_q == S_SHIFT_DATA && count_q == '0)
                         ? make_frame(1'b1, DATA_W'(cmd_q))
                         : make_frame(1'b0, w_head);

    always_ff @(posedge clk) begin
        if (w_push) begin
            fifo_q[wr_ptr_q] <= op_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            cmd_q       <= '0;
            shift_q     <= '0;
            bits_left_q <= '0;
            sout_q      <= 1'b1;
            sout_en_q   <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (w_push) begin
                        wr_ptr_q <= ptr_inc(wr_ptr_q);
                        count_q  <= w_eff_count;
                    end
                    if (w_cmd) begin
                        if (w_eff_count < CNT_W'(MIN_OPS)) begin
                            err_q    <= 1'b1;
                            count_q  <= '0;
                            wr_ptr_q <= '0;
                            rd_ptr_q <= '0;
                        end else begin
                            cmd_q       <= cmd_code;
                            state_q     <= S_SHIFT_DATA;
                            busy_q      <= 1'b1;
                            sout_q      <= w_frame[F-1];
                            sout_en_q   <= 1'b1;
                            shift_q     <= {w_frame[F-2:0], 1'b0};
                            bits_left_q <= BIT_W'(F - 1);
                            rd_ptr_q    <= ptr_inc(rd_ptr_q);
                            count_q     <= w_eff_count - CNT_W'(1);
                        end
                    end
                end
                S_SHIFT_DATA, S_SHIFT_CMD: begin
                    if (bits_left_q != '0) begin
                        sout_q      <= shift_q[F-1];
                        shift_q     <= {shift_q[F-2:0], 1'b0};
                        bits_left_q <= bits_left_q - BIT_W'(1);
                    end else if (state_q == S_SHIFT_CMD) begin
                        state_q   <= S_DONE;
                        sout_q    <= 1'b1;
                        sout_en_q <= 1'b0;
                        busy_q    <= 1'b0;
                        done_q    <= 1'b1;
                    end else begin
                        // Next frame starts on the cycle right after the last bit.
                        sout_q      <= w_frame[F-1];
                        shift_q     <= {w_frame[F-2:0], 1'b0};
                        bits_left_q <= BIT_W'(F - 1);
                        if (count_q != '0) begin
                            rd_ptr_q <= ptr_inc(rd_ptr_q);
                            count_q  <= count_q - CNT_W'(1);
                        end else begin
                            state_q <= S_SHIFT_CMD;
                        end
                    end
                end
                S_DONE: begin
                    state_q  <= S_IDLE;
                    count_q  <= '0;
                    wr_ptr_q <= '0;
                    rd_ptr_q <= '0;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign op_ready  = w_idle && (count_q < CNT_W'(MAX_OPS));
    assign cmd_ready = w_idle;
    assign sout      = sout_q;
    assign sout_en   = sout_en_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;
    assign count     = count_q;

endmodule

`default_nettype wire

// File: doc/alu_frame_tx.md
# alu_frame_tx

Parametrised serial frame transmitter for the multi-operand serial ALU. It buffers 2..MAX_OPS operands pushed over a valid/ready port and, on a command request, serialises them MSB-first onto a single-bit line as parity-protected data frames followed by one command frame. It is the synthesizable successor to the bench-side frame builder and can drive the ALU's serial input from on-chip logic, generalised in operand width and operand count.

## Interface
- DATA_W, 8, payload bits per frame; frame length F = DATA_W+2; legal DATA_W >= CMD_W.
- CMD_W, 8, command code width; zero-extended on the MSB side to DATA_W in the command frame.
- MAX_OPS, 9, operand FIFO depth and maximum operands per command.
- MIN_OPS, 2, minimum operands per command; 1 <= MIN_OPS <= MAX_OPS.
- clk  in  1  single clock; all logic on posedge.
- rst_n  in  1  asynchronous, active-low reset.
- op_valid  in  1  operand push request.
- op_ready  out  1  operand accepted when op_valid && op_ready.
- op_data  in  DATA_W  operand value.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  command accepted when cmd_valid && cmd_ready.
- cmd_code  in  CMD_W  command code.
- sout  out  1  serial frame line; idles 1.
- sout_en  out  1  high on every cycle a frame bit is driven on sout.
- busy  out  1  transmission in progress.
- done  out  1  one-cycle pulse after last command-frame bit.
- err  out  1  one-cycle pulse on rejected command.
- count  out  $clog2(MAX_OPS+1)  operands currently buffered.

## Operation
- Frame, MSB first: bit F-1 = type (0 data, 1 command); bits F-2..1 = payload MSB first; bit 0 = parity = ~^ of bits F-1..1, so every frame carries an odd number of ones.
- States: IDLE, SHIFT_DATA, SHIFT_CMD, DONE.
- IDLE: op_ready = (count < MAX_OPS); cmd_ready = 1. An operand push and a command in the same cycle: the operand is enqueued and included in that command.
- Command accepted with effective count (including same-cycle push) < MIN_OPS: no transmission, FIFO flushed to 0, err pulses next cycle, remain IDLE.
- Command accepted with effective count >= MIN_OPS: latch cmd_code; go to SHIFT_DATA; busy = 1; op_ready = cmd_ready = 0 until return to IDLE.
- SHIFT_DATA: pop the FIFO head, shift its F bits out, repeat until the FIFO is empty, then go to SHIFT_CMD. Frames are back to back with no idle bits.
- SHIFT_CMD: shift the F command-frame bits, then go to DONE.
- DONE: done = 1 for one cycle, busy = 0, count = 0; next state IDLE.
- Push while full or busy: op_ready = 0, data ignored, no error.

## Timing
- Reset values: sout = 1, sout_en = 0, op_ready = 1, cmd_ready = 1, busy = 0, done = 0, err = 0, count = 0, state IDLE, FIFO empty.
- Reset asserted mid-transmission: all outputs take reset values immediately (asynchronous), the partial frame is abandoned, buffered operands are discarded, and done is not pulsed.
- Command accepted at posedge T: busy = 1 and the first bit (type of operand 0) appears on sout with sout_en = 1 from T+1.
- N operands: sout_en is high for exactly (N+1)*F consecutive cycles, T+1 .. T+(N+1)*F. done is high in cycle T+(N+1)*F+1. op_ready and cmd_ready are high again in cycle T+(N+1)*F+2.
- count increments in the cycle after an accepted push and decrements when each data frame starts.
- err is high in cycle T+1 for a rejected command at T.

## Test plan
- DATA_W=8: push 0x00, 0xFF; cmd 0x01 -> sout = 0000000001 0111111111 1000000011 (30 bits), sout_en 30 cycles, done at T+31.
- Push 9 operands (0x01..0x09) -> op_ready falls at count = 9; a 10th push is ignored; cmd 0x04 -> 100 frame bits with the operands in push order and every frame odd parity.
- Push 1 operand, then cmd -> err pulse at T+1, count returns to 0, sout stays 1, no done.
- Push the second operand in the same cycle as cmd_valid -> accepted, 3 frames sent.
- Assert rst_n low in the middle of the second frame -> sout = 1, sout_en = 0, count = 0 immediately; a fresh 2-operand command afterwards transmits correctly.
- DATA_W=12, MAX_OPS=4: push 0xABC, 0x000, cmd 0x07 -> 14-bit frames; command payload = 0x007; 42 bits; done at T+43.
